// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: the command-master FSM state encoding, response
// codes and the default protection value.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake into one AXI-Lite
// write or read at a time. Every output is a flop; nothing combinational reaches a port.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_AXI_LITE_ADDR_WIDTH = 16,
  parameter int C_AXI_LITE_DATA_WIDTH = 32
) (
  input  logic                                 M_AXI_ACLK,
  input  logic                                 M_AXI_ARESET,

  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_wr,
  input  logic [C_AXI_LITE_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_AXI_LITE_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_AXI_LITE_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic                                 rsp_wr,
  output logic [1:0]                           rsp_resp,
  output logic [C_AXI_LITE_DATA_WIDTH-1:0]     rsp_rdata,

  output logic [C_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                           M_AXI_AWPROT,
  output logic                                 M_AXI_AWVALID,
  input  logic                                 M_AXI_AWREADY,
  output logic [C_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_AXI_LITE_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                                 M_AXI_WVALID,
  input  logic                                 M_AXI_WREADY,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic                                 M_AXI_BVALID,
  output logic                                 M_AXI_BREADY,
  output logic [C_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                           M_AXI_ARPROT,
  output logic                                 M_AXI_ARVALID,
  input  logic                                 M_AXI_ARREADY,
  input  logic [C_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                           M_AXI_RRESP,
  input  logic                                 M_AXI_RVALID,
  output logic                                 M_AXI_RREADY
);

  state_t state_reg, state_next;
  logic   aw_done_reg, aw_done_next;
  logic   w_done_reg, w_done_next;

  logic cmd_accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_accept = cmd_valid & cmd_ready;
  assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs       = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs       = M_AXI_RVALID & M_AXI_RREADY;
  assign rsp_hs     = rsp_valid & rsp_ready;

  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // aw/w completion flags include this cycle's handshakes, so a same-cycle finish
  // of the later channel moves straight on to the response phase.
  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_wr ? WR_REQ : RD_ADDR;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: if (b_hs)   state_next = RSP;
      RD_ADDR: if (ar_hs)  state_next = RD_DATA;
      RD_DATA: if (r_hs)   state_next = RSP;
      RSP:     if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of what the next state wants.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      cmd_ready     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
    end else begin
      cmd_ready     <= (state_next == IDLE);
      M_AXI_AWVALID <= (state_next == WR_REQ) && !aw_done_next;
      M_AXI_WVALID  <= (state_next == WR_REQ) && !w_done_next;
      M_AXI_BREADY  <= (state_next == WR_RESP);
      M_AXI_ARVALID <= (state_next == RD_ADDR);
      M_AXI_RREADY  <= (state_next == RD_DATA);
      rsp_valid     <= (state_next == RSP);
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      M_AXI_AWADDR <= '0;
      M_AXI_WDATA  <= '0;
      M_AXI_WSTRB  <= '0;
      M_AXI_ARADDR <= '0;
    end else if (cmd_accept) begin
      if (cmd_wr) begin
        M_AXI_AWADDR <= cmd_addr;
        M_AXI_WDATA  <= cmd_wdata;
        M_AXI_WSTRB  <= cmd_wstrb;
      end else begin
        M_AXI_ARADDR <= cmd_addr;
      end
    end
  end

  // Response fields only change on a B/R capture, so they hold through any rsp stall.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      rsp_wr    <= 1'b0;
      rsp_resp  <= RESP_OKAY;
      rsp_rdata <= '0;
    end else if (b_hs) begin
      rsp_wr    <= 1'b1;
      rsp_resp  <= M_AXI_BRESP;
      rsp_rdata <= '0;
    end else if (r_hs) begin
      rsp_wr    <= 1'b0;
      rsp_resp  <= M_AXI_RRESP;
      rsp_rdata <= M_AXI_RDATA;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a delay-configurable AXI-Lite register slave
// (word 0 = GPIO out, word 1 = GPIO in) plus an array model of expected contents.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_wr;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;

  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int n_cmp = 0;
  int n_err = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] gpio_in = '0;
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.C_AXI_LITE_ADDR_WIDTH(16), .C_AXI_LITE_DATA_WIDTH(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  logic        aw_got, w_got;
  logic [15:0] s_awaddr;
  logic [31:0] s_wdata, sel_data;
  logic [3:0]  s_wstrb, sel_strb;
  logic [15:0] sel_addr;
  int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic [31:0] mem [16];
  logic        aw_hs, w_hs, ar_hs;

  assign awready  = awvalid && (aw_cnt >= aw_delay) && !aw_got;
  assign wready   = wvalid && (w_cnt >= w_delay) && !w_got;
  assign arready  = arvalid && (ar_cnt >= ar_delay);
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign ar_hs    = arvalid & arready;
  assign sel_addr = aw_got ? s_awaddr : awaddr;
  assign sel_data = w_got ? s_wdata : wdata;
  assign sel_strb = w_got ? s_wstrb : wstrb;
  assign bresp    = b_resp_cfg;
  assign rresp    = r_resp_cfg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if (b_wait > 0) begin b_wait <= b_wait - 1; if (b_wait == 1) bvalid <= 1'b1; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        if (sel_addr[5:2] != 4'd1)
          for (int k = 0; k < 4; k++)
            if (sel_strb[k]) mem[sel_addr[5:2]][8*k +: 8] <= sel_data[8*k +: 8];
        if (b_delay == 0) bvalid <= 1'b1; else b_wait <= b_delay;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (r_wait > 0) begin r_wait <= r_wait - 1; if (r_wait == 1) rvalid <= 1'b1; end
      if (ar_hs) begin
        ar_cnt <= 0;
        rdata  <= (araddr[5:2] == 4'd1) ? gpio_in : mem[araddr[5:2]];
        if (r_delay == 0) rvalid <= 1'b1; else r_wait <= r_delay;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (cmd_ready === 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Returns latency in cycles counted from the accept edge (cycle 1 = first after accept).
  task automatic wait_rsp(input int stall, output bit ok, output int lat, output logic wr,
                          output logic [1:0] resp, output logic [31:0] rd);
    ok = 1'b0; lat = 0; wr = 1'bx; resp = 2'bxx; rd = 'x;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = i; ok = 1'b1; break; end
    end
    if (ok) begin
      repeat (stall) @(negedge clk);
      wr = rsp_wr; resp = rsp_resp; rd = rsp_rdata;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    $display("txn: rsp ok=%0d wr=%b resp=%b rdata=%h lat=%0d", ok, wr, resp, rd, lat);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [150:0] outs;
    repeat (2) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    outs = {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_wr, rsp_resp, rsp_rdata,
            awaddr, wdata, wstrb, araddr, awprot, arprot};
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if ({awvalid, wvalid, arvalid, rsp_valid} !== 4'b0) begin n_err++; $display("FAIL reset_release_valids: got %b expected 0000", {awvalid, wvalid, arvalid, rsp_valid}); end
  endtask

  task automatic test_write_timing();
    bit ok;
    aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    send_cmd(1'b1, 16'h0000, 32'hA5A5_0001, 4'hF, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_accept: got 0 expected 1"); end
    @(negedge clk);
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b110) begin n_err++; $display("FAIL wr_c1_valids: got %b expected 110", {awvalid, wvalid, bready}); end
    n_cmp++; if ({awaddr, wdata, wstrb} !== {16'h0000, 32'hA5A5_0001, 4'hF}) begin n_err++; $display("FAIL wr_c1_payload: got %h expected %h", {awaddr, wdata, wstrb}, {16'h0000, 32'hA5A5_0001, 4'hF}); end
    @(negedge clk);
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++; $display("FAIL wr_c2_bready: got %b expected 001", {awvalid, wvalid, bready}); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 1'b1, 2'b00, 32'h0}) begin n_err++; $display("FAIL wr_c3_rsp: got %h expected %h", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0}); end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    $display("txn: write addr=0000 data=a5a50001 resp=%b", rsp_resp);
    ref_mem[0] = 32'hA5A5_0001;
    n_cmp++; if (mem[0] !== ref_mem[0]) begin n_err++; $display("FAIL wr_gpio_out: got %h expected %h", mem[0], ref_mem[0]); end
  endtask

  task automatic test_read_timing();
    bit ok;
    ar_delay = 0; r_delay = 0; r_resp_cfg = 2'b00; gpio_in = 32'h1234_5678;
    send_cmd(1'b0, 16'h0004, 32'hDEAD_BEEF, 4'h0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_accept: got 0 expected 1"); end
    @(negedge clk);
    n_cmp++; if ({arvalid, rready, araddr} !== {1'b1, 1'b0, 16'h0004}) begin n_err++; $display("FAIL rd_c1_ar: got %h expected %h", {arvalid, rready, araddr}, {1'b1, 1'b0, 16'h0004}); end
    @(negedge clk);
    n_cmp++; if ({arvalid, rready} !== 2'b01) begin n_err++; $display("FAIL rd_c2_rready: got %b expected 01", {arvalid, rready}); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 32'h1234_5678}) begin n_err++; $display("FAIL rd_c3_rsp: got %h expected %h", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h1234_5678}); end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    $display("txn: read addr=0004 rdata=%h resp=%b", rsp_rdata, rsp_resp);
  endtask

  task automatic test_w_before_aw();
    bit ok; int lat; logic wr; logic [1:0] resp; logic [31:0] rd, d;
    aw_delay = 3; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    d = $urandom();
    send_cmd(1'b1, 16'h0008, d, 4'hF, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wfirst_accept: got 0 expected 1"); end
    @(negedge clk);
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b110) begin n_err++; $display("FAIL wfirst_c1: got %b expected 110", {awvalid, wvalid, bready}); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_err++; $display("FAIL wfirst_c%0d: got %b expected 100", c, {awvalid, wvalid, bready}); end
    end
    @(negedge clk);
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++; $display("FAIL wfirst_c5: got %b expected 001", {awvalid, wvalid, bready}); end
    wait_rsp(0, ok, lat, wr, resp, rd);
    n_cmp++; if ({ok, wr, resp} !== {1'b1, 1'b1, 2'b00}) begin n_err++; $display("FAIL wfirst_rsp: got %b expected 1100", {ok, wr, resp}); end
    ref_mem[2] = d;
    n_cmp++; if (mem[2] !== ref_mem[2]) begin n_err++; $display("FAIL wfirst_data: got %h expected %h", mem[2], ref_mem[2]); end
    aw_delay = 0;
  endtask

  task automatic test_slverr();
    bit ok; int lat; logic wr; logic [1:0] resp; logic [31:0] rd, d;
    d = $urandom();
    b_resp_cfg = 2'b10;
    send_cmd(1'b1, 16'h000C, d, 4'hF, ok);
    wait_rsp(0, ok, lat, wr, resp, rd);
    ref_mem[3] = d;
    n_cmp++; if ({ok, wr, resp, rd} !== {1'b1, 1'b1, 2'b10, 32'h0}) begin n_err++; $display("FAIL slverr_rsp: got %h expected %h", {ok, wr, resp, rd}, {1'b1, 1'b1, 2'b10, 32'h0}); end
    b_resp_cfg = 2'b00;
    send_cmd(1'b0, 16'h000C, 32'h0, 4'h0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL slverr_next_accept: got 0 expected 1"); end
    wait_rsp(0, ok, lat, wr, resp, rd);
    n_cmp++; if ({ok, wr, resp, rd, lat} !== {1'b1, 1'b0, 2'b00, ref_mem[3], 32'd3}) begin n_err++; $display("FAIL slverr_next_rsp: got %h expected %h", {ok, wr, resp, rd, lat}, {1'b1, 1'b0, 2'b00, ref_mem[3], 32'd3}); end
  endtask

  task automatic test_rsp_stall();
    bit ok, seen; logic [31:0] exp;
    exp = $urandom(); gpio_in = exp;
    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = (rsp_valid === 1'b1); end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL stall_rsp_timeout: got 0 expected 1"); end
    gpio_in = ~exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if ({rsp_valid, cmd_ready, rsp_rdata} !== {1'b1, 1'b0, exp}) begin n_err++; $display("FAIL stall_hold_c%0d: got %h expected %h", c, {rsp_valid, cmd_ready, rsp_rdata}, {1'b1, 1'b0, exp}); end
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    $display("txn: stalled read rdata=%h", rsp_rdata);
    @(negedge clk);
    n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL stall_idle: got %b expected 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int lat; logic wr; logic [1:0] resp; logic [31:0] rd, g;
    b_delay = 6;
    send_cmd(1'b1, 16'h0014, $urandom(), 4'hF, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = (bready === 1'b1); end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_bready_timeout: got 0 expected 1"); end
    rst = 1'b1; #1;
    n_cmp++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin n_err++; $display("FAIL rstmid_outputs: got %b expected 0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}); end
    $display("txn: write addr=0014 aborted by reset");
    @(negedge clk);
    rst = 1'b0; b_delay = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready); end
    g = $urandom(); gpio_in = g;
    send_cmd(1'b0, 16'h0004, 32'h0, 4'h0, ok);
    wait_rsp(0, ok, lat, wr, resp, rd);
    n_cmp++; if ({ok, wr, resp, rd, lat} !== {1'b1, 1'b0, 2'b00, g, 32'd3}) begin n_err++; $display("FAIL rstmid_fresh_read: got %h expected %h", {ok, wr, resp, rd, lat}, {1'b1, 1'b0, 2'b00, g, 32'd3}); end
  endtask

  task automatic test_random();
    bit ok; int lat, exp_lat, word, stall; logic wr, twr; logic [1:0] resp, exp_resp;
    logic [31:0] rd, d, exp_rd; logic [3:0] s;
    for (int t = 0; t < 40; t++) begin
      twr = 1'($urandom_range(0, 1)); word = $urandom_range(0, 15);
      d = $urandom(); s = 4'($urandom_range(0, 15)); stall = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      gpio_in = $urandom();
      if (twr) begin
        exp_lat  = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
        exp_resp = b_resp_cfg; exp_rd = '0;
        if (word != 1) ref_mem[word] = merge(ref_mem[word], d, s);
      end else begin
        exp_lat  = 3 + ar_delay + r_delay;
        exp_resp = r_resp_cfg;
        exp_rd   = (word == 1) ? gpio_in : ref_mem[word];
      end
      send_cmd(twr, 16'(word * 4), d, s, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rand%0d_accept: got 0 expected 1", t); end
      wait_rsp(stall, ok, lat, wr, resp, rd);
      n_cmp++;
      if ({ok, wr, resp, rd} !== {1'b1, twr, exp_resp, exp_rd} || lat != exp_lat) begin
        n_err++;
        $display("FAIL rand%0d_rsp: got ok=%b wr=%b resp=%b rdata=%h lat=%0d expected 1 %b %b %h %0d",
                 t, ok, wr, resp, rd, lat, twr, exp_resp, exp_rd, exp_lat);
      end
    end
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read_timing();
    test_w_before_aw();
    test_slverr();
    test_rsp_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
